// File: rtl/core_run_ctrl.sv
// Run controller for up to eight processor cores. It holds the cores in reset,
// releases them in a staggered sequence, times a bounded run and tracks per-core halts.
module core_run_ctrl #(
  parameter int N_CH         = 1,
  parameter int RESET_CYCLES = 5,
  parameter int STAGGER      = 0,
  parameter int RUN_CYCLES   = 241,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [N_CH-1:0]  i_halt_req,
  output logic [N_CH-1:0]  o_core_rst,
  output logic             o_running,
  output logic             o_done,
  output logic [N_CH-1:0]  o_halted,
  output logic [CNT_W-1:0] o_cycle
);

  localparam longint L_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] L_RC_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("core_run_ctrl: N_CH must be in 1..8");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cntw
    $error("core_run_ctrl: CNT_W must be in 1..32");
  end
  if (RESET_CYCLES < 1 || longint'(RESET_CYCLES) > L_MAX) begin : g_bad_rc
    $error("core_run_ctrl: RESET_CYCLES out of range for CNT_W");
  end
  if (RUN_CYCLES < 1 || longint'(RUN_CYCLES) > L_MAX) begin : g_bad_run
    $error("core_run_ctrl: RUN_CYCLES out of range for CNT_W");
  end
  if (STAGGER < 0 || longint'(N_CH - 1) * longint'(STAGGER) > L_MAX) begin : g_bad_stagger
    $error("core_run_ctrl: release offsets do not fit the counter");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_core_rst;
  logic             r_running;
  logic             r_done;
  logic [N_CH-1:0]  r_halted;

  logic             w_sync_ok;
  logic             w_halt_en;
  logic [CNT_W-1:0] w_inc;
  logic [N_CH-1:0]  w_halted_nxt;
  logic [N_CH-1:0]  w_rel_hit;
  logic [N_CH-1:0]  w_zero_ofs;

  // The FSM may only leave HOLD once reset release has crossed two flops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_sync_ok    = r_sync[1];
  assign w_inc        = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + L_ONE;
  assign w_halt_en    = (r_state == S_RELEASE) || (r_state == S_RUN);
  assign w_halted_nxt = r_halted | (i_halt_req & {N_CH{w_halt_en}});

  for (genvar g = 0; g < N_CH; g++) begin : g_ofs
    localparam logic [CNT_W-1:0] L_OFS = CNT_W'(g * STAGGER);
    assign w_rel_hit[g]  = (w_inc == L_OFS);
    assign w_zero_ofs[g] = (L_OFS == '0);
  end

  // Release decisions look at the incremented count so that o_cycle shows the
  // offset on the same clock the matching channel leaves reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_core_rst <= '1;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_halted   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_state    <= S_HOLD;
        r_cnt      <= '0;
        r_core_rst <= '1;
        r_running  <= 1'b0;
        r_halted   <= '0;
      end else begin
        case (r_state)
          S_HOLD: begin
            r_core_rst <= '1;
            r_running  <= 1'b0;
            if (w_sync_ok) begin
              if (r_cnt == L_RC_LAST) begin
                r_cnt      <= '0;
                r_core_rst <= ~w_zero_ofs;
                if (w_zero_ofs[N_CH-1]) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                end else begin
                  r_state <= S_RELEASE;
                end
              end else begin
                r_cnt <= w_inc;
              end
            end
          end
          S_RELEASE: begin
            r_halted   <= w_halted_nxt;
            r_core_rst <= w_halted_nxt | (r_core_rst & ~w_rel_hit);
            if (w_rel_hit[N_CH-1]) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= w_inc;
            end
          end
          S_RUN: begin
            r_halted <= w_halted_nxt;
            if ((r_cnt == L_RUN_LAST) || (&w_halted_nxt)) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_running  <= 1'b0;
              r_core_rst <= '1;
              r_cnt      <= '0;
            end else begin
              r_core_rst <= w_halted_nxt;
              r_cnt      <= w_inc;
            end
          end
          S_DONE: begin
            r_core_rst <= '1;
            r_running  <= 1'b0;
            r_cnt      <= w_inc;
          end
          default: begin
            r_state    <= S_HOLD;
            r_cnt      <= '0;
            r_core_rst <= '1;
            r_running  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_core_rst = r_core_rst;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_halted   = r_halted;
  assign o_cycle    = r_cnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two configurations checked every clock against a
// timeline model of the run sequence, plus a few hand-computed waypoints.
module tb_core_run_ctrl;

  localparam int A_N = 2, A_RC = 5, A_S = 0, A_RUN = 241, A_W = 16;
  localparam int B_N = 4, B_RC = 3, B_S = 3, B_RUN = 60,  B_W = 8;
  localparam int BIG = 1000000000;
  localparam int PH_HOLD = 0, PH_REL = 1, PH_RUN = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b0;
  logic [A_N-1:0] haltA = '0;
  logic [B_N-1:0] haltB = '0;

  logic [A_N-1:0] aCoreRst, aHalted;
  logic           aRunning, aDone;
  logic [A_W-1:0] aCycle;
  logic [B_N-1:0] bCoreRst, bHalted;
  logic           bRunning, bDone;
  logic [B_W-1:0] bCycle;

  int testsRun = 0;
  int testsFailed = 0;
  int edgeCnt = 0;

  int cfgN   [2] = '{A_N, B_N};
  int cfgRc  [2] = '{A_RC, B_RC};
  int cfgS   [2] = '{A_S, B_S};
  int cfgRun [2] = '{A_RUN, B_RUN};
  int cfgMax [2] = '{65535, 255};

  // Model state: edge at which HOLD's count sits at 0, early-end edge, halt mask.
  int         orig    [2] = '{BIG, BIG};
  int         early   [2] = '{-1, -1};
  logic [7:0] mHalted [2] = '{8'h0, 8'h0};

  always #5 clk = ~clk;

  core_run_ctrl #(.N_CH(A_N), .RESET_CYCLES(A_RC), .STAGGER(A_S),
                  .RUN_CYCLES(A_RUN), .CNT_W(A_W)) dutA (
    .i_clk(clk), .i_rst(rstN), .i_start(start), .i_halt_req(haltA),
    .o_core_rst(aCoreRst), .o_running(aRunning), .o_done(aDone),
    .o_halted(aHalted), .o_cycle(aCycle));

  core_run_ctrl #(.N_CH(B_N), .RESET_CYCLES(B_RC), .STAGGER(B_S),
                  .RUN_CYCLES(B_RUN), .CNT_W(B_W)) dutB (
    .i_clk(clk), .i_rst(rstN), .i_start(start), .i_halt_req(haltB),
    .o_core_rst(bCoreRst), .o_running(bRunning), .o_done(bDone),
    .o_halted(bHalted), .o_cycle(bCycle));

  function automatic int lastRel(input int i);
    return cfgRc[i] + (cfgN[i] - 1) * cfgS[i];
  endfunction

  function automatic int endEdge(input int i);
    int natural;
    natural = orig[i] + lastRel(i) + cfgRun[i];
    return (early[i] >= 0 && early[i] < natural) ? early[i] : natural;
  endfunction

  function automatic int phaseAt(input int i, input int n);
    int d;
    d = n - orig[i];
    if (d < cfgRc[i]) return PH_HOLD;
    if (n >= endEdge(i)) return PH_DONE;
    if (d < lastRel(i)) return PH_REL;
    return PH_RUN;
  endfunction

  function automatic logic [7:0] allMask(input int i);
    return 8'((1 << cfgN[i]) - 1);
  endfunction

  task automatic modelUpdate();
    int ph;
    logic [7:0] req;
    for (int i = 0; i < 2; i++) begin
      req = (i == 0) ? 8'(haltA) : 8'(haltB);
      if (!rstN) begin
        orig[i] = BIG; early[i] = -1; mHalted[i] = '0;
      end else if (orig[i] == BIG) begin
        orig[i] = edgeCnt + 1;
      end else if (start) begin
        orig[i] = edgeCnt; early[i] = -1; mHalted[i] = '0;
      end else begin
        ph = phaseAt(i, edgeCnt - 1);
        if (ph == PH_REL || ph == PH_RUN) mHalted[i] = mHalted[i] | req;
        if (ph == PH_RUN && mHalted[i] == allMask(i)) early[i] = edgeCnt;
      end
    end
  endtask

  task automatic modelExpect(input int i, input int n, output logic [7:0] eRst,
                             output logic eRun, output logic eDone, output int eCyc);
    int d, e;
    d = n - orig[i];
    eRst = allMask(i); eRun = 1'b0; eDone = 1'b0; eCyc = 0;
    case (phaseAt(i, n))
      PH_HOLD: eCyc = (d < 0) ? 0 : d;
      PH_REL: begin
        eCyc = d - cfgRc[i];
        for (int k = 0; k < cfgN[i]; k++)
          if (!mHalted[i][k] && d >= cfgRc[i] + k * cfgS[i]) eRst[k] = 1'b0;
      end
      PH_RUN: begin
        eRst = mHalted[i]; eRun = 1'b1; eCyc = d - lastRel(i);
      end
      default: begin
        e = endEdge(i);
        eDone = (n == e);
        eCyc = (n - e > cfgMax[i]) ? cfgMax[i] : n - e;
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    testsRun++;
    if (act !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeCnt, act, want);
    end
  endtask

  task automatic compareModel();
    logic [7:0] eRst, actRst, actHalt;
    logic eRun, eDone, actRun, actDone;
    int eCyc, actCyc;
    string pfx;
    for (int i = 0; i < 2; i++) begin
      modelExpect(i, edgeCnt, eRst, eRun, eDone, eCyc);
      pfx     = (i == 0) ? "A" : "B";
      actRst  = (i == 0) ? 8'(aCoreRst) : 8'(bCoreRst);
      actHalt = (i == 0) ? 8'(aHalted) : 8'(bHalted);
      actRun  = (i == 0) ? aRunning : bRunning;
      actDone = (i == 0) ? aDone : bDone;
      actCyc  = (i == 0) ? int'(aCycle) : int'(bCycle);
      checkOutput({pfx, ".o_core_rst"}, 32'(actRst), 32'(eRst));
      checkOutput({pfx, ".o_halted"}, 32'(actHalt), 32'(mHalted[i]));
      checkOutput({pfx, ".o_running"}, 32'(actRun), 32'(eRun));
      checkOutput({pfx, ".o_done"}, 32'(actDone), 32'(eDone));
      checkOutput({pfx, ".o_cycle"}, 32'(actCyc), 32'(eCyc));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edgeCnt++;
    modelUpdate();
    compareModel();
  endtask

  task automatic applyStimulus(input logic rstV, input logic startV,
                               input logic [A_N-1:0] hA, input logic [B_N-1:0] hB);
    @(negedge clk);
    rstN = rstV; start = startV; haltA = hA; haltB = hB;
    step();
  endtask

  task automatic waitEdge(input int e);
    while (edgeCnt < e) applyStimulus(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    int r, s, n, sinceRst;
    logic doStart;
    logic [A_N-1:0] hA;
    logic [B_N-1:0] hB;

    repeat (3) applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("lit reset A.o_core_rst", 32'(aCoreRst), 32'h3);
    checkOutput("lit reset B.o_core_rst", 32'(bCoreRst), 32'hF);
    checkOutput("lit reset A.o_cycle", 32'(aCycle), 32'h0);

    // First run from reset release: A releases 2+5 clocks later, B staggers by 3.
    r = edgeCnt;
    applyStimulus(1'b1, 1'b0, '0, '0);
    waitEdge(r + 6);
    checkOutput("lit A rst held at +6", 32'(aCoreRst), 32'h3);
    checkOutput("lit B ch0 released", 32'(bCoreRst), 32'hE);
    waitEdge(r + 7);
    checkOutput("lit A rst falls at +7", 32'(aCoreRst), 32'h0);
    checkOutput("lit A running at +7", 32'(aRunning), 32'h1);
    waitEdge(r + 8);
    checkOutput("lit B ch1 released", 32'(bCoreRst), 32'hC);
    waitEdge(r + 11);
    checkOutput("lit B ch2 released", 32'(bCoreRst), 32'h8);
    checkOutput("lit B not yet running", 32'(bRunning), 32'h0);
    waitEdge(r + 14);
    checkOutput("lit B ch3 released", 32'(bCoreRst), 32'h0);
    checkOutput("lit B running with ch3", 32'(bRunning), 32'h1);

    waitEdge(r + 17);
    applyStimulus(1'b1, 1'b0, 2'b10, '0);
    checkOutput("lit A halted ch1", 32'(aHalted), 32'h2);
    checkOutput("lit A ch1 back in reset", 32'(aCoreRst), 32'h2);
    checkOutput("lit A cycle 11", 32'(aCycle), 32'd11);

    waitEdge(r + 247);
    checkOutput("lit A last run cycle", 32'(aCycle), 32'd240);
    waitEdge(r + 248);
    checkOutput("lit A done pulse", 32'(aDone), 32'h1);
    checkOutput("lit A resets reassert", 32'(aCoreRst), 32'h3);
    waitEdge(r + 249);
    checkOutput("lit A done one clock", 32'(aDone), 32'h0);
    waitEdge(r + 340);
    checkOutput("lit B DONE count saturates", 32'(bCycle), 32'hFF);

    // Restart, then halt both A channels by run cycle 20 for an early end.
    applyStimulus(1'b1, 1'b1, '0, '0);
    s = edgeCnt;
    waitEdge(s + 10);
    applyStimulus(1'b1, 1'b0, 2'b01, '0);
    waitEdge(s + 25);
    applyStimulus(1'b1, 1'b0, 2'b10, '0);
    checkOutput("lit A early done", 32'(aDone), 32'h1);
    checkOutput("lit A both halted", 32'(aHalted), 32'h3);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("lit A DONE sticky", 32'(aRunning), 32'h0);

    // Restart, halt ch0, then restart again at run cycle 100.
    applyStimulus(1'b1, 1'b1, '0, '0);
    s = edgeCnt;
    waitEdge(s + 35);
    applyStimulus(1'b1, 1'b0, 2'b01, '0);
    waitEdge(s + 105);
    applyStimulus(1'b1, 1'b1, '0, '0);
    checkOutput("lit A restart rst", 32'(aCoreRst), 32'h3);
    checkOutput("lit A restart halted clear", 32'(aHalted), 32'h0);
    checkOutput("lit A restart cycle", 32'(aCycle), 32'h0);
    s = edgeCnt;
    waitEdge(s + 246);
    checkOutput("lit A full run after restart", 32'(aDone), 32'h1);

    // Asynchronous reset at run cycle 50 aborts without a done pulse.
    applyStimulus(1'b1, 1'b1, '0, '0);
    s = edgeCnt;
    waitEdge(s + 55);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("lit async A.o_core_rst", 32'(aCoreRst), 32'h3);
    checkOutput("lit async A.o_running", 32'(aRunning), 32'h0);
    checkOutput("lit async A.o_cycle", 32'(aCycle), 32'h0);
    checkOutput("lit async A.o_done", 32'(aDone), 32'h0);
    checkOutput("lit async B.o_core_rst", 32'(bCoreRst), 32'hF);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    waitEdge(edgeCnt + 260);

    // Randomized traffic: sparse halts, occasional restarts and resets.
    sinceRst = 10;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0);
        sinceRst = 0;
      end
      doStart = (sinceRst > 5) && ($urandom_range(0, 299) == 0);
      for (int k = 0; k < A_N; k++) hA[k] = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < B_N; k++) hB[k] = ($urandom_range(0, 63) == 0);
      applyStimulus(1'b1, doStart, hA, hB);
      sinceRst++;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
